// File: rtl/acc_diff.sv
// Recovers per-sample increments from a stream of unsigned running sums.
// Valid/ready in and out, single output register, frame counter and sticky wrap flag.
module acc_diff #(
  parameter int BIT   = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in_valid,
  input  logic [BIT-1:0]   data_in,
  output logic             data_in_ready,
  input  logic             clr,
  output logic             data_out_valid,
  output logic [BIT-1:0]   data_out,
  input  logic             data_out_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_wrap
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       state_q, state_d;
  logic [BIT-1:0]   prev_q, prev_d;
  logic [BIT-1:0]   dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             accept;
  logic             in_run;
  logic [BIT-1:0]   ref_val;

  assign data_in_ready  = !dvalid_q || data_out_ready;
  assign accept         = data_in_valid && data_in_ready;
  // A coincident clr makes this sample the first of a new frame.
  assign in_run         = (state_q == RUN) && !clr;
  assign ref_val        = in_run ? prev_q : '0;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    if (accept) begin
      dout_d   = data_in - ref_val;
      dvalid_d = 1'b1;
      prev_d   = data_in;
      state_d  = RUN;
      if (clr) begin
        cnt_d = CNT_W'(1);
        err_d = 1'b0;
      end else begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (in_run && (data_in < prev_q)) err_d = 1'b1;
      end
    end else begin
      if (dvalid_q && data_out_ready) dvalid_d = 1'b0;
      // Frame restart leaves the output register alone.
      if (clr) begin
        state_d = IDLE;
        prev_d  = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign data_out_valid = dvalid_q;
  assign data_out       = dout_q;
  assign frame_cnt      = cnt_q;
  assign err_wrap       = err_q;

endmodule

// File: tb/tb_acc_diff.sv
// Bench for acc_diff: frame-level reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_acc_diff;

  localparam int BIT   = 8;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             data_in_valid = 1'b0;
  logic [BIT-1:0]   data_in = '0;
  logic             data_in_ready;
  logic             clr = 1'b0;
  logic             data_out_valid;
  logic [BIT-1:0]   data_out;
  logic             data_out_ready = 1'b1;
  logic [CNT_W-1:0] frame_cnt;
  logic             err_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  acc_diff #(.BIT(BIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .data_in_valid(data_in_valid), .data_in(data_in), .data_in_ready(data_in_ready),
    .clr(clr),
    .data_out_valid(data_out_valid), .data_out(data_out), .data_out_ready(data_out_ready),
    .frame_cnt(frame_cnt), .err_wrap(err_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame is a list of sums; an output is the latest sum
  // minus the one before it (or minus 0 for the first sum of a frame).
  bit          m_known = 0;
  bit          m_has_prev;
  int          m_prev;
  bit          m_valid;
  int          m_data;
  int          m_cnt;
  bit          m_err;

  always @(posedge clk) begin
    bit acc;
    int base;
    if (rst) begin
      m_known = 1; m_has_prev = 0; m_prev = 0;
      m_valid = 0; m_data = 0; m_cnt = 0; m_err = 0;
    end else if (m_known) begin
      acc = data_in_valid && (!m_valid || data_out_ready);
      if (acc) begin
        base = (m_has_prev && !clr) ? m_prev : 0;
        m_data = (int'(data_in) - base + (1 << BIT)) % (1 << BIT);
        m_valid = 1;
        if (clr) begin
          m_err = 0;
          m_cnt = 1;
        end else begin
          if (m_has_prev && int'(data_in) < m_prev) m_err = 1;
          m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        end
        m_prev = int'(data_in);
        m_has_prev = 1;
      end else begin
        if (m_valid && data_out_ready) m_valid = 0;
        if (clr) begin
          m_has_prev = 0; m_prev = 0; m_cnt = 0; m_err = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("out_valid", int'(data_out_valid), int'(m_valid));
      if (m_valid) check("out_data", int'(data_out), m_data);
      check("frame_cnt", int'(frame_cnt), m_cnt);
      check("err_wrap", int'(err_wrap), int'(m_err));
      check("in_ready", int'(data_in_ready), int'(!m_valid || data_out_ready));
      $display("cyc t=%0t in=%0d v=%0b clr=%0b -> out=%0d ov=%0b cnt=%0d err=%0b",
               $time, data_in, data_in_valid, clr, data_out, data_out_valid, frame_cnt, err_wrap);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; data_in_valid = 0; clr = 0; data_out_ready = 1;
    step();
    rst = 0;
  endtask

  task automatic send(input int v, input bit c);
    data_in_valid = 1; data_in = BIT'(v); clr = c;
    step();
    data_in_valid = 0; clr = 0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_valid", int'(data_out_valid), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_cnt", int'(frame_cnt), 0);
    check("rst_err", int'(err_wrap), 0);
    rst = 0;
    #1 check("rst_ready", int'(data_in_ready), 1);

    // Basic: 5,12,12,40 -> 5,7,0,28
    send(5, 0);  check("basic0", int'(data_out), 5);
    send(12, 0); check("basic1", int'(data_out), 7);
    send(12, 0); check("basic2", int'(data_out), 0);
    send(40, 0); check("basic3", int'(data_out), 28);
    check("basic_cnt", int'(frame_cnt), 4);
    check("basic_err", int'(err_wrap), 0);
    step();

    // Backpressure: 10 then 30 stalled for 3 cycles
    do_reset();
    send(10, 0);
    data_in_valid = 1; data_in = 30; data_out_ready = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", int'(data_in_ready), 0);
      check("bp_hold", int'(data_out), 10);
      check("bp_cnt", int'(frame_cnt), 1);
      step();
    end
    data_out_ready = 1;
    step();
    data_in_valid = 0;
    check("bp_out", int'(data_out), 20);
    check("bp_cnt2", int'(frame_cnt), 2);
    step();

    // Clear alone, then 30
    do_reset();
    send(100, 0); check("clr_a0", int'(data_out), 100);
    send(150, 0); check("clr_a1", int'(data_out), 50);
    clr = 1; step(); clr = 0;
    check("clr_cnt0", int'(frame_cnt), 0);
    send(30, 0);  check("clr_a2", int'(data_out), 30);
    check("clr_cnt1", int'(frame_cnt), 1);

    // Clear coincident with sample 30
    do_reset();
    send(100, 0);
    send(150, 0);
    send(30, 1);  check("clr_b", int'(data_out), 30);
    check("clr_b_cnt", int'(frame_cnt), 1);
    check("clr_b_err", int'(err_wrap), 0);

    // Wrap: 250 then 4 -> 10 with err_wrap, clr clears it
    do_reset();
    send(250, 0);
    send(4, 0);   check("wrap_out", int'(data_out), 10);
    check("wrap_err", int'(err_wrap), 1);
    send(20, 0);  check("wrap_sticky", int'(err_wrap), 1);
    clr = 1; step(); clr = 0;
    check("wrap_clr", int'(err_wrap), 0);

    // Saturation at 7
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      send(i * 3, 0);
      check("sat_cnt", int'(frame_cnt), (i > 7) ? 7 : i);
    end

    // Reset mid-stream with sample present
    do_reset();
    send(3, 0);
    rst = 1; data_in_valid = 1; data_in = 7;
    step();
    rst = 0; data_in_valid = 0;
    check("mid_valid", int'(data_out_valid), 0);
    check("mid_data", int'(data_out), 0);
    check("mid_cnt", int'(frame_cnt), 0);
    send(9, 0);   check("mid_next", int'(data_out), 9);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_diff.md
ACC_DIFF -- requirements
Module: acc_diff

Interface
REQ-001 SHALL have parameter BIT, default 32, data width of input sums and output differences.
REQ-002 SHALL have parameter CNT_W, default 16, width of frame sample counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port data_in_valid  input  1  running-sum sample present.
REQ-006 SHALL have port data_in  input  BIT  running-sum sample, unsigned.
REQ-007 SHALL have port data_in_ready  output  1  block accepts sample this cycle.
REQ-008 SHALL have port clr  input  1  frame restart; next difference taken against zero.
REQ-009 SHALL have port data_out_valid  output  1  difference held in output register.
REQ-010 SHALL have port data_out  output  BIT  recovered increment (current sum minus previous sum).
REQ-011 SHALL have port data_out_ready  input  1  downstream consumes output this cycle.
REQ-012 SHALL have port frame_cnt  output  CNT_W  samples accepted since last clr/rst.
REQ-013 SHALL have port err_wrap  output  1  sticky: a sample below its predecessor was seen in current frame.

Function
REQ-014 SHALL accept a sample ("accept") when data_in_valid && data_in_ready.
REQ-015 SHALL drive data_in_ready = !data_out_valid || data_out_ready (combinational, no skid).
REQ-016 SHALL present the difference for an accepted sample on data_out with data_out_valid high in the cycle after acceptance (latency 1).
REQ-017 SHALL hold data_out and data_out_valid stable while data_out_valid && !data_out_ready.
REQ-018 SHALL clear data_out_valid after a cycle with data_out_valid && data_out_ready and no accept; on simultaneous consume and accept, load the new difference, data_out_valid stays 1.
REQ-019 SHALL implement states IDLE (no previous sum; reference value 0) and RUN (previous sum prev registered).
REQ-020 SHALL, in IDLE on accept, output data_in - 0, set prev <= data_in, go to RUN.
REQ-021 SHALL, in RUN on accept, output (data_in - prev) modulo 2^BIT, set prev <= data_in, stay RUN.
REQ-022 SHALL, on accept in RUN with data_in < prev, set err_wrap to 1; output still the modulo difference.
REQ-023 SHALL, on clr without accept, go to IDLE, prev <= 0, frame_cnt <= 0, err_wrap <= 0; output register and data_out_valid unaffected.
REQ-024 SHALL, on clr with accept in same cycle, treat the sample as first of the new frame: output data_in, prev <= data_in, state RUN, frame_cnt <= 1, err_wrap <= 0.
REQ-025 SHALL increment frame_cnt by 1 per accept, saturating at 2^CNT_W-1 (no wrap).
REQ-026 SHALL ignore data_in when data_in_valid is low or data_in_ready is low; no state change except via clr.

Reset
REQ-027 SHALL, with rst high at a rising edge, set state IDLE, prev 0, data_out 0, data_out_valid 0, frame_cnt 0, err_wrap 0.
REQ-028 SHALL give rst priority over clr and accept; a sample presented during rst is dropped.
REQ-029 SHALL drive data_in_ready high in the first cycle after rst deasserts (data_out_valid is 0).

Verification
REQ-030 Basic: rst, then sums 5, 12, 12, 40 back-to-back, data_out_ready=1 -> data_out 5, 7, 0, 28 on consecutive cycles one cycle after each input; frame_cnt ends 4; err_wrap 0.
REQ-031 Backpressure: data_out_ready=0 for 3 cycles after first output of sums 10, 30 -> data_out holds 10, data_in_ready 0 those cycles, 30 not accepted until ready returns; then output 20.
REQ-032 Clear: sums 100, 150, clr alone, then 30 -> outputs 100, 50, 30; frame_cnt 1 after 30. Repeat with clr coincident with sample 30 -> same output 30, frame_cnt 1.
REQ-033 Wrap: BIT=8, sums 250 then 4 -> second output 10 (0x0A), err_wrap 1; subsequent clr -> err_wrap 0.
REQ-034 Saturation: CNT_W=3, 9 accepted samples -> frame_cnt 1..7 then holds 7.
REQ-035 Reset mid-stream: rst asserted while data_out_valid=1 and sample presented -> next cycle data_out_valid 0, data_out 0, frame_cnt 0; next sample 9 outputs 9.
